multi_tone_sound_generator: RTL and testbench



---
 rtl/multi_tone_sound_generator_if.sv | 28 ++
 rtl/multi_tone_sound_generator.sv | 182 ++++++++++++++++++
 tb/tb_multi_tone_sound_generator.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/multi_tone_sound_generator_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : multi_tone_sound_generator_if
// Brief   : Event inputs and audio outputs of the multi-tone sound generator.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
interface multi_tone_sound_generator_if #(
  parameter int N = 8
);
  logic         goodColl_i;
  logic         badColl_i;
  logic         button_i;
  logic [3:0]   direction_i;
  logic [N-1:0] soundOut;
  logic         playing_o;
  logic         mode_o;

  modport master (
    output goodColl_i, badColl_i, button_i, direction_i,
    input  soundOut, playing_o, mode_o
  );

  modport slave (
    input  goodColl_i, badColl_i, button_i, direction_i,
    output soundOut, playing_o, mode_o
  );
endinterface
`default_nettype wire

// File: rtl/multi_tone_sound_generator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : multi_tone_sound_generator
// Brief   : Event-driven, priority-arbitrated sawtooth tone generator with a
//           button-toggled ON/OFF mode. Optional decay envelope: SOUND_ENVELOPE_EN.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module multi_tone_sound_generator #(
  parameter int               N        = 8,
  parameter int               DIV_W    = 16,
  parameter logic [DIV_W-1:0] GOOD_DIV = 16'd1000,
  parameter logic [DIV_W-1:0] BAD_DIV  = 16'd2000,
  parameter logic [DIV_W-1:0] DIR_DIV  = 16'd500,
  parameter int               DUR_W    = 24,
  parameter logic [DUR_W-1:0] TONE_DUR = 24'd6000000
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  multi_tone_sound_generator_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  localparam logic [1:0] PRI_DIR  = 2'd0;
  localparam logic [1:0] PRI_GOOD = 2'd1;
  localparam logic [1:0] PRI_BAD  = 2'd2;

  logic             good_cur, good_prev;
  logic             bad_cur, bad_prev;
  logic             btn_cur, btn_prev;
  logic [3:0]       dir_cur, dir_prev;

  state_t           state, state_n;
  logic             mode, mode_n;
  logic [DIV_W-1:0] cur_div, cur_div_n;
  logic [1:0]       cur_pri, cur_pri_n;
  logic [DUR_W-1:0] dur_cnt, dur_cnt_n;
  logic [DIV_W-1:0] div_cnt, div_cnt_n;
  logic [N-1:0]     saw, saw_n;
  logic [N-1:0]     sound, sound_n;

  logic             good_ev, bad_ev, btn_ev, dir_ev, any_ev;
  logic [1:0]       ev_pri;
  logic [DIV_W-1:0] ev_div;
  logic             load;

  // Inputs are registered once; prev holds the value from the cycle before.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      good_cur  <= 1'b0;
      good_prev <= 1'b0;
      bad_cur   <= 1'b0;
      bad_prev  <= 1'b0;
      btn_cur   <= 1'b0;
      btn_prev  <= 1'b0;
      dir_cur   <= 4'd0;
      dir_prev  <= 4'd0;
    end else begin
      good_cur  <= bus.goodColl_i;
      good_prev <= good_cur;
      bad_cur   <= bus.badColl_i;
      bad_prev  <= bad_cur;
      btn_cur   <= bus.button_i;
      btn_prev  <= btn_cur;
      dir_cur   <= bus.direction_i;
      dir_prev  <= dir_cur;
    end
  end

  assign good_ev = good_cur & ~good_prev;
  assign bad_ev  = bad_cur & ~bad_prev;
  assign btn_ev  = btn_cur & ~btn_prev;
  assign dir_ev  = (dir_cur != dir_prev) && (dir_cur != 4'd0);
  assign any_ev  = good_ev | bad_ev | dir_ev;

  always_comb begin
    ev_pri = PRI_DIR;
    ev_div = DIR_DIV;
    if (bad_ev) begin
      ev_pri = PRI_BAD;
      ev_div = BAD_DIV;
    end else if (good_ev) begin
      ev_pri = PRI_GOOD;
      ev_div = GOOD_DIV;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    mode_n    = mode;
    cur_div_n = cur_div;
    cur_pri_n = cur_pri;
    dur_cnt_n = dur_cnt;
    div_cnt_n = div_cnt;
    saw_n     = saw;
    load      = 1'b0;

    if (btn_ev) mode_n = ~mode;

    // Turning OFF silences at once and swallows any event of the same cycle.
    if (mode && btn_ev) begin
      state_n = IDLE;
    end else if (mode) begin
      case (state)
        IDLE: begin
          if (any_ev) load = 1'b1;
        end
        PLAY: begin
          if (any_ev && (ev_pri >= cur_pri)) begin
            load = 1'b1;
          end else begin
            if (div_cnt == cur_div - DIV_W'(1)) begin
              div_cnt_n = '0;
              saw_n     = saw + N'(1);
            end else begin
              div_cnt_n = div_cnt + DIV_W'(1);
            end
            if (dur_cnt == DUR_W'(1)) state_n = IDLE;
            else                      dur_cnt_n = dur_cnt - DUR_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end

    if (load) begin
      state_n   = PLAY;
      cur_div_n = ev_div;
      cur_pri_n = ev_pri;
      dur_cnt_n = TONE_DUR;
      div_cnt_n = '0;
      saw_n     = '0;
    end
  end

`ifdef SOUND_ENVELOPE_EN
  logic [1:0] env_shift;
  // Quartile of the remaining duration sets the attenuation step.
  always_comb begin
    env_shift = 2'd3 - dur_cnt_n[DUR_W-1 -: 2];
    sound_n   = (state_n == PLAY) ? (saw_n >> env_shift) : '0;
  end
`else
  always_comb begin
    sound_n = (state_n == PLAY) ? saw_n : '0;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode    <= 1'b1;
      cur_div <= '0;
      cur_pri <= '0;
      dur_cnt <= '0;
      div_cnt <= '0;
      saw     <= '0;
      sound   <= '0;
    end else begin
      mode    <= mode_n;
      cur_div <= cur_div_n;
      cur_pri <= cur_pri_n;
      dur_cnt <= dur_cnt_n;
      div_cnt <= div_cnt_n;
      saw     <= saw_n;
      sound   <= sound_n;
    end
  end

  assign bus.soundOut  = sound;
  assign bus.playing_o = (state == PLAY);
  assign bus.mode_o    = mode;

endmodule
`default_nettype wire

// File: tb/tb_multi_tone_sound_generator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_multi_tone_sound_generator
// Brief   : Table, directed and random checks against a time-based tone model.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_multi_tone_sound_generator;
  localparam int N     = 4;
  localparam int DUR   = 20;
  localparam int GDIV  = 4;
  localparam int BDIV  = 2;
  localparam int DDIV  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_tone_sound_generator_if #(.N(N)) bus ();

  multi_tone_sound_generator #(
    .N(N), .DIV_W(16), .GOOD_DIV(16'd4), .BAD_DIV(16'd2), .DIR_DIV(16'd8),
    .DUR_W(5), .TONE_DUR(5'd20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int passed = 0;
  int total  = 0;

  // Model: mode, whether a tone runs, its class and cycles since it began.
  bit       m_mode, m_active;
  int       m_t, m_cls;
  bit       x1g, x2g, x1b, x2b, x1bt, x2bt, drv_g, drv_b, drv_bt;
  bit [3:0] x1d, x2d, drv_d;

  typedef struct {
    bit       g;
    bit       b;
    bit [3:0] d_from;
    bit [3:0] d_to;
    bit       tone;
    int       div;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int div_of(input int c);
    return (c == 2) ? BDIV : (c == 1) ? GDIV : DDIV;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_edge();
    bit ge, be, bte, de;
    int best;
    ge  = x1g & ~x2g;
    be  = x1b & ~x2b;
    bte = x1bt & ~x2bt;
    de  = (x1d != x2d) && (x1d != 4'd0);
    best = be ? 2 : ge ? 1 : de ? 0 : -1;
    if (bte) begin
      if (m_mode) m_active = 1'b0;
      m_mode = ~m_mode;
    end else if (m_mode) begin
      if (best >= 0 && (!m_active || best >= m_cls)) begin
        m_active = 1'b1;
        m_cls    = best;
        m_t      = 0;
      end else if (m_active) begin
        m_t++;
        if (m_t >= DUR) m_active = 1'b0;
      end
    end
    x2g = x1g;  x2b = x1b;  x2bt = x1bt;  x2d = x1d;
    x1g = drv_g; x1b = drv_b; x1bt = drv_bt; x1d = drv_d;
  endtask

  task automatic drive(input bit g, input bit b, input bit bt, input bit [3:0] d);
    drv_g = g; drv_b = b; drv_bt = bt; drv_d = d;
    bus.goodColl_i  = g;
    bus.badColl_i   = b;
    bus.button_i    = bt;
    bus.direction_i = d;
  endtask

  // One clock: advance DUT and model, compare, then drive inputs for the next edge.
  task automatic cyc(input bit g, input bit b, input bit bt, input bit [3:0] d);
    int exp_sound;
    tick();
    model_edge();
    exp_sound = m_active ? (m_t / div_of(m_cls)) % 16 : 0;
    check("model_playing", int'(bus.playing_o), int'(m_active));
    check("model_sound", int'(bus.soundOut), exp_sound);
    check("model_mode", int'(bus.mode_o), int'(m_mode));
    drive(g, b, bt, d);
  endtask

  task automatic model_reset();
    m_mode = 1'b1; m_active = 1'b0; m_t = 0; m_cls = 0;
    x1g = 0; x2g = 0; x1b = 0; x2b = 0; x1bt = 0; x2bt = 0; x1d = 0; x2d = 0;
  endtask

  task automatic do_reset(input bit hold_g);
    rst = 1'b1;
    drive(hold_g, 1'b0, 1'b0, 4'd0);
    repeat (2) tick();
    check("reset_sound", int'(bus.soundOut), 0);
    check("reset_playing", int'(bus.playing_o), 0);
    check("reset_mode", int'(bus.mode_o), 1);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int tones;
    bit prev_play;
    bit rg, rb;
    bit [3:0] rd;

    vecs[0] = '{1'b1, 1'b0, 4'd0, 4'd0, 1'b1, GDIV};
    vecs[1] = '{1'b0, 1'b1, 4'd0, 4'd0, 1'b1, BDIV};
    vecs[2] = '{1'b1, 1'b1, 4'd0, 4'd0, 1'b1, BDIV};
    vecs[3] = '{1'b0, 1'b0, 4'd0, 4'd3, 1'b1, DDIV};
    vecs[4] = '{1'b0, 1'b0, 4'd3, 4'd0, 1'b0, 1};
    vecs[5] = '{1'b0, 1'b0, 4'd3, 4'd5, 1'b1, DDIV};
    vecs[6] = '{1'b1, 1'b0, 4'd3, 4'd7, 1'b1, GDIV};

    model_reset();
    drive(1'b0, 1'b0, 1'b0, 4'd0);

    // Single-event tones with hand-stated step period.
    foreach (vecs[i]) begin
      do_reset(1'b0);
      repeat (30) cyc(1'b0, 1'b0, 1'b0, vecs[i].d_from);
      cyc(vecs[i].g, vecs[i].b, 1'b0, vecs[i].d_to);
      cyc(1'b0, 1'b0, 1'b0, vecs[i].d_to);
      for (int t = 0; t < 24; t++) begin
        cyc(1'b0, 1'b0, 1'b0, vecs[i].d_to);
        check("tbl_playing", int'(bus.playing_o), int'(vecs[i].tone && t < DUR));
        check("tbl_sound", int'(bus.soundOut),
              (vecs[i].tone && t < DUR) ? (t / vecs[i].div) % 16 : 0);
      end
    end

    // Good tone restarted by bad, then a good during bad is ignored.
    do_reset(1'b0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    repeat (6) cyc(1'b0, 1'b0, 1'b0, 4'd0);
    cyc(1'b0, 1'b1, 1'b0, 4'd0);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 4'd0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    repeat (30) cyc(1'b0, 1'b0, 1'b0, 4'd0);

    // Mode OFF blocks events; ON again; button mid-tone cuts it.
    do_reset(1'b0);
    cyc(1'b0, 1'b0, 1'b1, 4'd0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 4'd0);
    check("mode_off", int'(bus.mode_o), 0);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 4'd0);
    check("off_silent", int'(bus.playing_o), 0);
    cyc(1'b0, 1'b0, 1'b1, 4'd0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 4'd0);
    check("mode_on", int'(bus.mode_o), 1);
    cyc(1'b1, 1'b0, 1'b0, 4'd0);
    repeat (10) cyc(1'b0, 1'b0, 1'b0, 4'd0);
    check("tone_before_cut", int'(bus.playing_o), 1);
    cyc(1'b0, 1'b0, 1'b1, 4'd0);
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 4'd0);
    check("cut_playing", int'(bus.playing_o), 0);
    check("cut_sound", int'(bus.soundOut), 0);
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 4'd0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 4'd0);

    // Asynchronous reset mid-tone with goodColl held high.
    do_reset(1'b0);
    repeat (12) cyc(1'b1, 1'b0, 1'b0, 4'd0);
    check("pre_reset_sound", int'(bus.soundOut), 2);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_sound", int'(bus.soundOut), 0);
    check("async_playing", int'(bus.playing_o), 0);
    check("async_mode", int'(bus.mode_o), 1);
    do_reset(1'b1);
    tones = 0;
    prev_play = 1'b0;
    repeat (50) begin
      cyc(1'b1, 1'b0, 1'b0, 4'd0);
      if (bus.playing_o && !prev_play) tones++;
      prev_play = bus.playing_o;
    end
    check("tones_after_reset", tones, 1);

    // Random event streams against the model.
    do_reset(1'b0);
    rg = 0; rb = 0; rd = 0;
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 11) == 0) rg = ~rg;
      if ($urandom_range(0, 13) == 0) rb = ~rb;
      if ($urandom_range(0, 19) == 0) rd = 4'($urandom_range(0, 15));
      cyc(rg, rb, ($urandom_range(0, 59) == 0), rd);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
`default_nettype wire
